// File: rtl/alu_exec_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : alu_exec_if
// Description : Operand / result bundle between the operand-select stage,
//               the execute stage (alu_exec) and write-back.
//               master = operand stage side, slave = execute stage side.
// Revision    : 1.0  initial release
// ============================================================================
interface alu_exec_if #(
  parameter int WIDTH = 16
);
  logic             en_in;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_func;
  logic [WIDTH-1:0] alu_out;
  logic             zf;
  logic             nf;
  logic             cf;
  logic             vf;
  logic             en_out;
  logic             busy;

  modport master (
    output en_in, alu_a, alu_b, alu_func,
    input  alu_out, zf, nf, cf, vf, en_out, busy
  );

  modport slave (
    input  en_in, alu_a, alu_b, alu_func,
    output alu_out, zf, nf, cf, vf, en_out, busy
  );
endinterface
`default_nettype wire

// File: rtl/alu_exec.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : alu_exec
// Description : 16-bit execute stage. Single-cycle add/sub/logic/shift/
//               compare ops; optional iterative shift-add multiply.
//               Config macro: ALU_MUL_EN (defined = multiply compiled in,
//               undefined = opcode 11 behaves as reserved, busy tied low).
// Revision    : 1.0  initial release
// ============================================================================
module alu_exec #(
  parameter int WIDTH = 16
) (
  input  logic      clk,
  input  logic      rst,
  alu_exec_if.slave bus
);

  localparam int c_SHW = $clog2(WIDTH);
  localparam int c_MSB = WIDTH - 1;

  localparam logic [3:0] c_OP_ADD   = 4'd0;
  localparam logic [3:0] c_OP_SUB   = 4'd1;
  localparam logic [3:0] c_OP_AND   = 4'd2;
  localparam logic [3:0] c_OP_OR    = 4'd3;
  localparam logic [3:0] c_OP_XOR   = 4'd4;
  localparam logic [3:0] c_OP_NOT   = 4'd5;
  localparam logic [3:0] c_OP_SLL   = 4'd6;
  localparam logic [3:0] c_OP_SRL   = 4'd7;
  localparam logic [3:0] c_OP_SRA   = 4'd8;
  localparam logic [3:0] c_OP_PASSB = 4'd9;
  localparam logic [3:0] c_OP_CMP   = 4'd10;
`ifdef ALU_MUL_EN
  localparam logic [3:0] c_OP_MUL   = 4'd11;
`endif

  // Registered outputs
  logic [WIDTH-1:0] r_alu_out;
  logic             r_zf, r_nf, r_cf, r_vf;
  logic             r_en_out;

  // Single-cycle datapath
  logic [c_SHW-1:0] w_sh;
  logic [WIDTH:0]   w_sum, w_diff, w_shl, w_shr, w_sra;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_flag_val;
  logic             w_cf, w_vf;

  // Next-state values
  logic [WIDTH-1:0] w_alu_out_nxt;
  logic             w_zf_nxt, w_nf_nxt, w_cf_nxt, w_vf_nxt;
  logic             w_en_out_nxt;

  assign w_sh = bus.alu_b[c_SHW-1:0];

  // Combinational result and flags for every single-cycle opcode
  always_comb begin
    w_sum  = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    w_diff = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
    // Shift with one guard bit so the last bit shifted out lands in it;
    // a zero shift leaves the guard bit 0, giving cf = 0 for free.
    w_shl  = {1'b0, bus.alu_a} << w_sh;
    w_shr  = {bus.alu_a, 1'b0} >> w_sh;
    w_sra  = $unsigned($signed({bus.alu_a, 1'b0}) >>> w_sh);
    w_res  = bus.alu_a;
    w_cf   = 1'b0;
    w_vf   = 1'b0;
    case (bus.alu_func)
      c_OP_ADD: begin
        w_res = w_sum[c_MSB:0];
        w_cf  = w_sum[WIDTH];
        w_vf  = (bus.alu_a[c_MSB] == bus.alu_b[c_MSB]) &&
                (w_sum[c_MSB] != bus.alu_a[c_MSB]);
      end
      c_OP_SUB, c_OP_CMP: begin
        w_res = w_diff[c_MSB:0];
        w_cf  = w_diff[WIDTH];
        w_vf  = (bus.alu_a[c_MSB] != bus.alu_b[c_MSB]) &&
                (w_diff[c_MSB] != bus.alu_a[c_MSB]);
      end
      c_OP_AND:   w_res = bus.alu_a & bus.alu_b;
      c_OP_OR:    w_res = bus.alu_a | bus.alu_b;
      c_OP_XOR:   w_res = bus.alu_a ^ bus.alu_b;
      c_OP_NOT:   w_res = ~bus.alu_a;
      c_OP_SLL: begin
        w_res = w_shl[c_MSB:0];
        w_cf  = w_shl[WIDTH];
      end
      c_OP_SRL: begin
        w_res = w_shr[WIDTH:1];
        w_cf  = w_shr[0];
      end
      c_OP_SRA: begin
        w_res = w_sra[WIDTH:1];
        w_cf  = w_sra[0];
      end
      c_OP_PASSB: w_res = bus.alu_b;
      default:    w_res = bus.alu_a;
    endcase
    w_flag_val = w_res;
  end

`ifdef ALU_MUL_EN
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  localparam logic [c_SHW-1:0] c_CNT_ONE = {{(c_SHW-1){1'b0}}, 1'b1};

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_mcand, w_mcand_nxt;
  logic [WIDTH-1:0]   r_mplier, w_mplier_nxt;
  logic [2*WIDTH-1:0] r_acc, w_acc_nxt, w_acc_step;
  logic [c_SHW-1:0]   r_cnt, w_cnt_nxt;
  logic               r_busy, w_busy_nxt;

  // Next-state / output decode: single-cycle issue, multiply start and
  // one shift-add iteration per cycle while in S_MUL
  always_comb begin
    w_state_nxt   = r_state;
    w_alu_out_nxt = r_alu_out;
    w_zf_nxt      = r_zf;
    w_nf_nxt      = r_nf;
    w_cf_nxt      = r_cf;
    w_vf_nxt      = r_vf;
    w_en_out_nxt  = 1'b0;
    w_busy_nxt    = 1'b0;
    w_mcand_nxt   = r_mcand;
    w_mplier_nxt  = r_mplier;
    w_acc_nxt     = r_acc;
    w_cnt_nxt     = r_cnt;
    w_acc_step    = r_acc + ({{WIDTH{1'b0}}, r_mcand} << r_cnt);
    case (r_state)
      S_IDLE: begin
        if (bus.en_in) begin
          if (bus.alu_func == c_OP_MUL) begin
            w_mcand_nxt  = bus.alu_a;
            w_mplier_nxt = bus.alu_b;
            w_acc_nxt    = '0;
            w_cnt_nxt    = '0;
            w_busy_nxt   = 1'b1;
            w_state_nxt  = S_MUL;
          end else begin
            // CMP updates flags only; the result register keeps its value
            if (bus.alu_func != c_OP_CMP) begin
              w_alu_out_nxt = w_res;
            end
            w_zf_nxt     = (w_flag_val == '0);
            w_nf_nxt     = w_flag_val[c_MSB];
            w_cf_nxt     = w_cf;
            w_vf_nxt     = w_vf;
            w_en_out_nxt = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (r_mplier[0]) begin
          w_acc_nxt = w_acc_step;
        end
        w_mplier_nxt = r_mplier >> 1;
        w_cnt_nxt    = r_cnt + c_CNT_ONE;
        if (&r_cnt) begin
          // Last iteration: publish the low half, flag a truncated product
          w_alu_out_nxt = w_acc_nxt[c_MSB:0];
          w_zf_nxt      = (w_acc_nxt[c_MSB:0] == '0);
          w_nf_nxt      = w_acc_nxt[c_MSB];
          w_cf_nxt      = |w_acc_nxt[2*WIDTH-1:WIDTH];
          w_vf_nxt      = |w_acc_nxt[2*WIDTH-1:WIDTH];
          w_en_out_nxt  = 1'b1;
          w_state_nxt   = S_IDLE;
        end else begin
          w_busy_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register and multiply working registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_acc    <= w_acc_nxt;
      r_cnt    <= w_cnt_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign bus.busy = r_busy;
`else
  // Next-value decode for the single-cycle-only build
  always_comb begin
    w_alu_out_nxt = r_alu_out;
    w_zf_nxt      = r_zf;
    w_nf_nxt      = r_nf;
    w_cf_nxt      = r_cf;
    w_vf_nxt      = r_vf;
    w_en_out_nxt  = 1'b0;
    if (bus.en_in) begin
      // CMP updates flags only; the result register keeps its value
      if (bus.alu_func != c_OP_CMP) begin
        w_alu_out_nxt = w_res;
      end
      w_zf_nxt     = (w_flag_val == '0);
      w_nf_nxt     = w_flag_val[c_MSB];
      w_cf_nxt     = w_cf;
      w_vf_nxt     = w_vf;
      w_en_out_nxt = 1'b1;
    end
  end

  assign bus.busy = 1'b0;
`endif

  // Result, flag and result-valid registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_out <= '0;
      r_zf      <= 1'b0;
      r_nf      <= 1'b0;
      r_cf      <= 1'b0;
      r_vf      <= 1'b0;
      r_en_out  <= 1'b0;
    end else begin
      r_alu_out <= w_alu_out_nxt;
      r_zf      <= w_zf_nxt;
      r_nf      <= w_nf_nxt;
      r_cf      <= w_cf_nxt;
      r_vf      <= w_vf_nxt;
      r_en_out  <= w_en_out_nxt;
    end
  end

  assign bus.alu_out = r_alu_out;
  assign bus.zf      = r_zf;
  assign bus.nf      = r_nf;
  assign bus.cf      = r_cf;
  assign bus.vf      = r_vf;
  assign bus.en_out  = r_en_out;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_alu_exec
// Description : Scoreboard bench for alu_exec. Stimulus pushes expected
//               results (value, flags, due cycle); a negedge monitor pops
//               one entry per en_out pulse. Honours ALU_MUL_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_exec;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_exec_if #(.WIDTH(16)) bus ();

  alu_exec #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic [15:0] out;
    logic [3:0]  zncv;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  int   nb;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
  endtask

  function automatic logic [31:0] outs();
    return {10'h0, bus.alu_out, bus.zf, bus.nf, bus.cf, bus.vf, bus.en_out, bus.busy};
  endfunction

  // Monitor: every result-valid pulse must match the oldest pending op
  always @(negedge clk) begin
    if (!rst && bus.en_out === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_en_out actual=en_out=1 alu_out=0x%0h required=no pulse (nothing pending)", bus.alu_out);
      end else begin
        m_e = sb.pop_front();
        chk({m_e.name, "_value"},
            {12'h0, bus.alu_out, bus.zf, bus.nf, bus.cf, bus.vf},
            {12'h0, m_e.out, m_e.zncv});
        chk({m_e.name, "_latency"}, cyc, m_e.due);
      end
    end
  end

  task automatic op(input string name, input logic [3:0] f,
                    input logic [15:0] a, input logic [15:0] b,
                    input logic [15:0] eo, input logic [3:0] zncv,
                    input int lat, input bit push);
    bus.en_in    = 1'b1;
    bus.alu_func = f;
    bus.alu_a    = a;
    bus.alu_b    = b;
    if (push) sb.push_back('{name: name, out: eo, zncv: zncv, due: cyc + lat});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.en_in = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    bus.en_in    = 1'b0;
    bus.alu_a    = '0;
    bus.alu_b    = '0;
    bus.alu_func = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", outs(), 32'h0);
    @(negedge clk) rst = 1'b0;
    idle(1);

    //         name          f      a        b        out      zncv     lat push
    op("add_ovf",     4'd0,  16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 1, 1);
    idle(2);
    op("sub_borrow",  4'd1,  16'h0003, 16'h0005, 16'hFFFE, 4'b0110, 1, 1);
    op("cmp_eq",      4'd10, 16'h1234, 16'h1234, 16'hFFFE, 4'b1000, 1, 1);
    op("sra1",        4'd8,  16'h8001, 16'h0001, 16'hC000, 4'b0110, 1, 1);
    op("sll0",        4'd6,  16'h0001, 16'h0000, 16'h0001, 4'b0000, 1, 1);
    op("srl2",        4'd7,  16'h8003, 16'h0002, 16'h2000, 4'b0010, 1, 1);
    op("sll1",        4'd6,  16'hC000, 16'h0001, 16'h8000, 4'b0110, 1, 1);
    op("and",         4'd2,  16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 1, 1);
    op("or",          4'd3,  16'h00F0, 16'h0F00, 16'h0FF0, 4'b0000, 1, 1);
    op("xor",         4'd4,  16'hFFFF, 16'hFFFF, 16'h0000, 4'b1000, 1, 1);
    op("not",         4'd5,  16'h00FF, 16'h1234, 16'hFF00, 4'b0100, 1, 1);
    op("passb",       4'd9,  16'h1111, 16'h8421, 16'h8421, 4'b0100, 1, 1);
    op("add_carry",   4'd0,  16'hFFFF, 16'h0001, 16'h0000, 4'b1010, 1, 1);
    op("sub_ovf",     4'd1,  16'h8000, 16'h0001, 16'h7FFF, 4'b0001, 1, 1);
    op("rsvd13",      4'd13, 16'hABCD, 16'h0000, 16'hABCD, 4'b0100, 1, 1);
    idle(3);

    // Asynchronous reset between clock edges after a valid result
    #2 rst = 1'b1;
    #1 chk("async_reset", outs(), 32'h0);
    @(negedge clk) rst = 1'b0;
    idle(1);

`ifdef ALU_MUL_EN
    op("mul", 4'd11, 16'h0100, 16'h0101, 16'h0100, 4'b0011, 17, 1);
    nb = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) nb++;
      if (i == 2) begin
        // ADD request while busy: must be ignored (nothing pushed)
        bus.alu_func = 4'd0;
        bus.alu_a    = 16'h1111;
        bus.alu_b    = 16'h2222;
        bus.en_in    = 1'b1;
      end else begin
        bus.en_in = 1'b0;
      end
    end
    chk("mul_busy_cycles", nb, 16);

    // Abort a multiply with reset in its 5th busy cycle
    op("mul_abort", 4'd11, 16'h0005, 16'h0007, 16'h0000, 4'b0000, 17, 0);
    bus.en_in = 1'b0;
    repeat (4) @(posedge clk);
    #2 chk("abort_busy_before_reset", {31'h0, bus.busy}, 32'h1);
    rst = 1'b1;
    #1 chk("abort_reset", outs(), 32'h0);
    @(negedge clk) rst = 1'b0;
    idle(20);
    op("add_after_abort", 4'd0, 16'h0002, 16'h0003, 16'h0005, 4'b0000, 1, 1);
    idle(2);
`else
    op("mul_as_rsvd", 4'd11, 16'h0003, 16'h0004, 16'h0003, 4'b0000, 1, 1);
    bus.en_in = 1'b0;
    nb = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0) nb++;
    end
    chk("busy_tied_low", nb, 0);
`endif

    idle(3);
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
